// File: rtl/jpeg_blk_pkg.sv
// Shared definitions for the block <-> raster converters of the JPEG_MOD datapath.
// Holds the block geometry, the raster read FSM states and the block-order address mapping.
package jpeg_blk_pkg;

  localparam int BLOCK_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE,
    LINE,
    BLANK
  } rd_state_t;

  // Buffer word address of a beat given its position inside the block row
  function automatic int blk_addr(input int elem, input int line, input int blk,
                                  input int x_res, input int n);
    return elem + line * (x_res / n) + blk * (BLOCK_SIZE / n);
  endfunction

endpackage

// File: rtl/blk_line_ram.sv
// Simple dual-port RAM holding one block row (8 video lines).
// One write port, one read port with a single registered read stage.
module blk_line_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/blocks_to_hdmi.sv
// Collects 8x8 blocks into ping-pong block-row buffers and replays them as raster lines
// with h/v sync markers and fixed horizontal blanking between lines.
module blocks_to_hdmi
  import jpeg_blk_pkg::*;
#(
  parameter int N       = 2,
  parameter int X_RES   = 2160,
  parameter int H_BLANK = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic signed [N-1:0][7:0] blk_data_y,
  input  logic signed [N-1:0][7:0] blk_data_cr,
  input  logic signed [N-1:0][7:0] blk_data_cb,
  input  logic                    blk_sob,
  input  logic                    blk_eob,
  input  logic                    blk_sof,
  output logic                    blk_err,
  output logic                    hdmi_v_sync,
  output logic                    hdmi_h_sync,
  output logic                    hdmi_data_valid,
  output logic signed [N-1:0][7:0] hdmi_data_y,
  output logic signed [N-1:0][7:0] hdmi_data_cr,
  output logic signed [N-1:0][7:0] hdmi_data_cb
);

  localparam int BPL   = BLOCK_SIZE / N;
  localparam int NBLK  = X_RES / BLOCK_SIZE;
  localparam int LW    = X_RES / N;
  localparam int DEPTH = LW * BLOCK_SIZE;
  localparam int AW    = $clog2(DEPTH);
  localparam int W     = 24 * N;
  localparam int EW    = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int BW    = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int CW    = (LW > 1) ? $clog2(LW) : 1;
  localparam int HW    = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;

  logic          wr_sel, rd_sel, rd_sel_d;
  logic [1:0]    full, sof_flag;
  logic [EW-1:0] elem, e_base, e_next;
  logic [2:0]    line, l_base, l_next;
  logic [BW-1:0] blk, b_base, b_next;
  logic          xfer, at_zero, restart, base_zero, base_last, row_done;
  logic          sob_bad, eob_bad;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data, q0, q1, out_word;

  rd_state_t     state, state_n;
  logic          rd_en, line_end, buf_done, cur_sof;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] col;
  logic [2:0]    rd_line;
  logic [HW-1:0] bcnt;
  logic          v1, hs1, vs1;

  assign blk_ready = !full[wr_sel];
  assign xfer      = blk_valid && blk_ready;
  assign at_zero   = (elem == '0) && (line == '0) && (blk == '0);
  assign restart   = xfer && blk_sof && !at_zero;
  assign sob_bad   = blk_sob && ((elem != '0) || (line != '0));
  assign eob_bad   = blk_eob && !((elem == EW'(BPL - 1)) && (line == 3'd7));
  assign wr_data   = {blk_data_cb, blk_data_cr, blk_data_y};

  // A misplaced sof restarts the row, so the beat is placed as if the counters were zero
  always_comb begin
    e_base = restart ? '0 : elem;
    l_base = restart ? '0 : line;
    b_base = restart ? '0 : blk;
    e_next = e_base;
    l_next = l_base;
    b_next = b_base;
    if (e_base == EW'(BPL - 1)) begin
      e_next = '0;
      if (l_base == 3'd7) begin
        l_next = '0;
        b_next = (b_base == BW'(NBLK - 1)) ? '0 : b_base + 1'b1;
      end else begin
        l_next = l_base + 1'b1;
      end
    end else begin
      e_next = e_base + 1'b1;
    end
    base_zero = (e_base == '0) && (l_base == '0) && (b_base == '0);
    base_last = (e_base == EW'(BPL - 1)) && (l_base == 3'd7) && (b_base == BW'(NBLK - 1));
    wr_addr   = AW'(blk_addr(int'(e_base), int'(l_base), int'(b_base), X_RES, N));
  end

  assign row_done = xfer && base_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem     <= '0;
      line     <= '0;
      blk      <= '0;
      wr_sel   <= 1'b0;
      sof_flag <= '0;
      blk_err  <= 1'b0;
    end else begin
      blk_err <= xfer && (restart || sob_bad || eob_bad);
      if (xfer) begin
        elem <= e_next;
        line <= l_next;
        blk  <= b_next;
        if (base_zero) sof_flag[wr_sel] <= blk_sof;
        if (row_done) wr_sel <= ~wr_sel;
      end
    end
  end

  // Set and clear never hit the same buffer: the writer only fills a non-full one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (row_done) full[wr_sel] <= 1'b1;
      if (buf_done) full[rd_sel] <= 1'b0;
    end
  end

  blk_line_ram #(.DEPTH(DEPTH), .WIDTH(W)) u_ram0 (
    .clk     (clk),
    .wr_en   (xfer && !wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en && !rd_sel),
    .rd_addr (rd_addr),
    .rd_data (q0)
  );

  blk_line_ram #(.DEPTH(DEPTH), .WIDTH(W)) u_ram1 (
    .clk     (clk),
    .wr_en   (xfer && wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en && rd_sel),
    .rd_addr (rd_addr),
    .rd_data (q1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    rd_en    = 1'b0;
    line_end = 1'b0;
    buf_done = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_sel]) state_n = LINE;
      end
      LINE: begin
        rd_en = 1'b1;
        if (col == CW'(LW - 1)) begin
          line_end = 1'b1;
          if (rd_line == 3'd7) begin
            buf_done = 1'b1;
            state_n  = IDLE;
          end else begin
            state_n = BLANK;
          end
        end
      end
      BLANK: begin
        if (bcnt == HW'(H_BLANK - 1)) state_n = LINE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Lines are contiguous in the buffer, so the address simply runs 0..DEPTH-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      col     <= '0;
      rd_line <= '0;
      bcnt    <= '0;
      rd_sel  <= 1'b0;
      cur_sof <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_addr <= '0;
          col     <= '0;
          rd_line <= '0;
          if (full[rd_sel]) cur_sof <= sof_flag[rd_sel];
        end
        LINE: begin
          rd_addr <= rd_addr + 1'b1;
          bcnt    <= '0;
          if (line_end) begin
            col     <= '0;
            rd_line <= rd_line + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        BLANK: bcnt <= bcnt + 1'b1;
        default: ;
      endcase
      if (buf_done) rd_sel <= ~rd_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1              <= 1'b0;
      hs1             <= 1'b0;
      vs1             <= 1'b0;
      rd_sel_d        <= 1'b0;
      hdmi_data_valid <= 1'b0;
      hdmi_h_sync     <= 1'b0;
      hdmi_v_sync     <= 1'b0;
      out_word        <= '0;
    end else begin
      v1              <= rd_en;
      hs1             <= rd_en && (col == '0);
      vs1             <= rd_en && (rd_addr == '0) && cur_sof;
      rd_sel_d        <= rd_sel;
      hdmi_data_valid <= v1;
      hdmi_h_sync     <= hs1;
      hdmi_v_sync     <= vs1;
      if (v1) out_word <= rd_sel_d ? q1 : q0;
    end
  end

  assign hdmi_data_y  = out_word[8*N-1:0];
  assign hdmi_data_cr = out_word[16*N-1:8*N];
  assign hdmi_data_cb = out_word[24*N-1:16*N];

endmodule
